// File: rtl/rv_dmux_pkg.sv
// Shared types and constants for the demux scheduler.
//   state_t : scheduler FSM state (IDLE = slot empty, HOLD = slot holds one transfer)
//   DROP_W  : width of the saturating dropped-request counter
package rv_dmux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DROP_W = 8;

endpackage

// File: rtl/rv_dmux_scheduler_arb.sv
// Round-robin arbiter used by the demux scheduler.
// Ports:
//   req   [R-1:0]  : request vector
//   ptr   [RI-1:0] : highest-priority index for this cycle
//   en             : qualifies grant; idx/any are reported regardless
//   grant [R-1:0]  : one-hot grant, all zero when en is low or no request
//   idx   [RI-1:0] : index of the winner (0 when no request)
//   any            : a winner exists
module rv_rr_arbiter #(
    parameter int R  = 4,
    parameter int RI = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  req,
    input  logic [RI-1:0] ptr,
    input  logic          en,
    output logic [R-1:0]  grant,
    output logic [RI-1:0] idx,
    output logic          any
);

    int j;

    // Walk the requesters starting at ptr, wrapping; the first one found wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < R; i++) begin
            j = (int'(ptr) + i) % R;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = RI'(j);
                grant[j] = en;
            end
        end
    end

endmodule

// File: rtl/rv_dmux_scheduler.sv
// Round-robin scheduler feeding a single-slot demux.
// R requesters compete for one holding slot; the held transfer is presented
// to destination sel_q via dmux_data_out/dmux_sel_out and a one-hot
// dst_valid_out. Requests naming a destination >= N are consumed and dropped.
//
// Handshake: a transfer moves on any interface in the cycle where its valid
// and ready are both high at the rising edge; valid, once raised by the
// scheduler, stays high with data stable until that cycle.
//
// Ports:
//   clk_in, rst_in            : clock, synchronous active-high reset
//   req_valid_in/dest/data    : per-requester transfer
//   req_ready_out             : per-requester accept (at most one bit high)
//   dmux_data_out/sel_out     : held payload and select
//   dst_valid_out/ready_in    : one-hot destination valid and per-destination ready
//   grant_id_out              : requester index of the held transfer
//   err_out                   : one-cycle pulse after a dropped request
//   drop_cnt_out              : saturating dropped-request count
//   state_dbg_out             : current FSM state
module rv_dmux_scheduler
    import rv_dmux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 5,
    parameter int R     = 4,
    parameter int S     = $clog2(N),
    // guarded so that R=1 still yields a 1-bit index
    parameter int RI    = (R > 1) ? $clog2(R) : 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [R-1:0]               req_valid_in,
    input  logic [R-1:0][S-1:0]        req_dest_in,
    input  logic [R-1:0][WIDTH-1:0]    req_data_in,
    output logic [R-1:0]               req_ready_out,
    output logic [WIDTH-1:0]           dmux_data_out,
    output logic [S-1:0]               dmux_sel_out,
    output logic [N-1:0]               dst_valid_out,
    input  logic [N-1:0]               dst_ready_in,
    output logic [RI-1:0]              grant_id_out,
    output logic                       err_out,
    output logic [DROP_W-1:0]          drop_cnt_out,
    output state_t                     state_dbg_out
);

    state_t              state, state_next;
    logic [RI-1:0]       ptr;
    logic [WIDTH-1:0]    data_q;
    logic [S-1:0]        sel_q;
    logic [RI-1:0]       grant_q;
    logic                err_q;
    logic [DROP_W-1:0]   drop_q;

    logic                complete;
    logic                slot_free;
    logic                arb_en;
    logic [R-1:0]        win_grant;
    logic [RI-1:0]       win_idx;
    logic                win_any;
    logic                accept;
    logic [S-1:0]        win_dest;
    logic [WIDTH-1:0]    win_data;
    logic                in_range;

    assign complete  = (state == HOLD) && dst_ready_in[sel_q];
    assign slot_free = (state == IDLE) || complete;
    // Reset masks the accept so nothing is consumed while rst_in is high.
    assign arb_en    = slot_free && !rst_in;

    rv_rr_arbiter #(.R(R), .RI(RI)) u_arb (
        .req   (req_valid_in),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign accept   = win_any && arb_en;
    assign win_dest = req_dest_in[win_idx];
    assign win_data = req_data_in[win_idx];
    assign in_range = int'(win_dest) < N;

    // Accept only happens with a free slot, so in HOLD it implies completion
    // and a new in-range accept keeps the slot occupied back-to-back.
    always_comb begin
        state_next    = state;
        dst_valid_out = '0;
        if (accept && in_range) begin
            state_next = HOLD;
        end else if (complete) begin
            state_next = IDLE;
        end
        if (state == HOLD) begin
            dst_valid_out = N'(1) << sel_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            ptr     <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state <= state_next;
            err_q <= accept && !in_range;
            if (accept) begin
                // For R=1 the winner is always 0 and this wraps to 0.
                ptr <= (win_idx == RI'(R - 1)) ? '0 : win_idx + 1'b1;
                if (in_range) begin
                    data_q  <= win_data;
                    sel_q   <= win_dest;
                    grant_q <= win_idx;
                end else if (drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
            end
        end
    end

    assign req_ready_out = win_grant;
    assign dmux_data_out = data_q;
    assign dmux_sel_out  = sel_q;
    assign grant_id_out  = grant_q;
    assign err_out       = err_q;
    assign drop_cnt_out  = drop_q;
    assign state_dbg_out = state;

endmodule
